// File: rtl/rs232_rx_fifo.sv
// First-word-fall-through byte FIFO behind the RS-232 receiver, with hysteretic CTS and sticky overflow.
// Optional RS232_RX_FIFO_DROP_COUNT_EN adds a saturating count of dropped bytes.
module rs232_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CTS_HIGH   = 12,
    parameter int CTS_LOW    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  rs232_ctsn,
    output logic                  overflow,
    input  logic                  overflow_clear
`ifdef RS232_RX_FIFO_DROP_COUNT_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL   = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] CTS_HI = CTS_HIGH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] CTS_LO = CTS_LOW[DEPTH_LOG2:0];

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_inc;
    logic [DEPTH_LOG2:0]   count_nxt, remain, push_ext, pop_ext;
    logic                  push, pop, full, drop, ovf_q;

    assign pop       = out_valid & out_ready;
    assign full      = (count == FULL);
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;
    assign push_ext  = {{DEPTH_LOG2{1'b0}}, push};
    assign pop_ext   = {{DEPTH_LOG2{1'b0}}, pop};
    assign count_nxt = count + push_ext - pop_ext;
    assign remain    = count - pop_ext;
    assign rd_inc    = rd_ptr + 1'b1;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            rs232_ctsn <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_inc;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            // Head register: the incoming byte becomes head when nothing else remains,
            // otherwise a pop exposes the next stored entry.
            if (push && remain == '0)
                out_data <= in_data;
            else if (pop && remain != '0)
                out_data <= mem[rd_inc];
            if (count_nxt >= CTS_HI)
                rs232_ctsn <= 1'b1;
            else if (count_nxt <= CTS_LO)
                rs232_ctsn <= 1'b0;
            if (drop)
                ovf_q <= 1'b1;
            else if (overflow_clear)
                ovf_q <= 1'b0;
        end
    end

`ifdef RS232_RX_FIFO_DROP_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            drop_count <= 8'h00;
        else if (drop && overflow_clear)
            drop_count <= 8'h01;
        else if (drop) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
        end else if (overflow_clear)
            drop_count <= 8'h00;
    end
    assign overflow = ovf_q | (drop_count != 8'h00);
`else
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Randomized and directed bench for rs232_rx_fifo against a queue-based reference model.
module tb_rs232_rx_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       rs232_ctsn;
    logic       overflow;
    logic       overflow_clear = 1'b0;
`ifdef RS232_RX_FIFO_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    rs232_rx_fifo dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .rs232_ctsn(rs232_ctsn), .overflow(overflow),
        .overflow_clear(overflow_clear)
`ifdef RS232_RX_FIFO_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_cts = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_drops = 0;
    logic [7:0] got[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cts = 1'b0;
        m_ovf = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_edge();
        bit p, full, drop;
        p    = (m_q.size() != 0) && out_ready;
        full = (m_q.size() == 16);
        drop = in_valid && full && !p;
        if (p) void'(m_q.pop_front());
        if (in_valid && !drop) m_q.push_back(in_data);
        if (m_q.size() >= 12) m_cts = 1'b1;
        else if (m_q.size() <= 4) m_cts = 1'b0;
        if (drop && overflow_clear) m_drops = 1;
        else if (drop) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
        else if (overflow_clear) m_drops = 0;
        if (drop) m_ovf = 1'b1;
        else if (overflow_clear) m_ovf = 1'b0;
    endtask

    task automatic compare();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
        chk("ctsn", 32'(rs232_ctsn), 32'(m_cts));
`ifdef RS232_RX_FIFO_DROP_COUNT_EN
        chk("drop_count", 32'(drop_count), 32'(m_drops));
        chk("overflow", 32'(overflow), 32'(m_ovf || m_drops != 0));
`else
        chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
    endtask

    // One clock: record what the consumer takes, update model at the edge, check 1 time unit later.
    task automatic step();
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        in_valid = v; in_data = d; out_ready = rdy; overflow_clear = clr;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        // 1. reset state, then a single byte
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ctsn", 32'(rs232_ctsn), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
        model_reset();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("single_data", 32'(out_data), 32'h A5);
        chk("single_count", 32'(count), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_empty", 32'(out_valid), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // 2. ordering and wrap with a permanent consumer
        got.delete();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            chk("wrap_cnt_le1", 32'(count <= 1), 1);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap_len", 32'(got.size()), 40);
        for (int i = 0; i < got.size(); i++) chk("wrap_order", 32'(got[i]), 32'(i));
        chk("wrap_ovf", 32'(overflow), 0);

        // 3. hysteresis
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
            chk("hyst_up", 32'(rs232_ctsn), 32'(i == 11));
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("hyst_down", 32'(rs232_ctsn), 32'(count > 4));
            drive(1'b0, 8'h00, 1'b0, 1'b0);
        end

        // 4. overflow
        got.delete();
        for (int i = 0; i < 18; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_flag", 32'(overflow), 1);
`ifdef RS232_RX_FIFO_DROP_COUNT_EN
        chk("ovf_drops", 32'(drop_count), 2);
`endif
        drain();
        chk("ovf_len", 32'(got.size()), 16);
        for (int i = 0; i < got.size(); i++) chk("ovf_order", 32'(got[i]), 32'(8'h10 + i));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow), 0);

        // 5. full with simultaneous pop and push
        got.delete();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_pp_count", 32'(count), 16);
        chk("full_pp_ovf", 32'(overflow), 0);
        drain();
        chk("full_pp_len", 32'(got.size()), 17);
        if (got.size() != 0) chk("full_pp_last", 32'(got[got.size()-1]), 32'h EE);

        // 6. async reset mid-cycle
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 7);
        #3 reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_ctsn", 32'(rs232_ctsn), 0);
        chk("arst_ovf", 32'(overflow), 0);
        model_reset();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_head", 32'(out_data), 32'h3C);
        drain();

        // Random traffic in phases of varying producer/consumer pressure
        for (int ph = 0; ph < 8; ph++) begin
            int pv = $urandom_range(20, 90);
            int pr = $urandom_range(10, 90);
            for (int i = 0; i < 300; i++)
                drive($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr,
                      $urandom_range(0, 99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
